mem_arbiter: RTL

- Shares the single external memory port between three line-fill/write-back requesters of the core: I-cache read (IC), D-cache read (DR), D-cache write (DW).
- Sits between the cache miss handlers and the top-level memory bus.
- Handles exactly one line transaction at a time.
- Grants are round-robin so instruction fetch cannot be starved by a store-heavy write buffer drain.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/rr_arbiter3.sv | 17 +
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
    localparam int LINE_WORDS_DEF = 4;
    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} arb_state_t;
    typedef enum logic [1:0] {OWN_IC = 2'd0, OWN_DR = 2'd1, OWN_DW = 2'd2, OWN_NONE = 2'd3} owner_t;
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin picker, search starts after last_grant
module rr_arbiter3 import mem_arb_pkg::*; (
    input  logic [2:0] req,
    input  owner_t     last_grant,
    output logic [2:0] grant,
    output owner_t     grant_id
);
    logic [1:0] p0, p1, p2;
    // rotate priority so the requester after the previous winner is checked first
    always_comb begin
        p0 = last_grant == OWN_IC ? 2'd1 : last_grant == OWN_DR ? 2'd2 : 2'd0;
        p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        grant_id = owner_t'(req[p0] ? p0 : req[p1] ? p1 : req[p2] ? p2 : 2'd3);
        grant = grant_id == OWN_NONE ? 3'b000 : 3'b001 << grant_id;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between IC read, DR read and DW write line transactions
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rdata_valid,
    output logic              ic_rdata_last,
    input  logic              dr_req_valid,
    input  logic [ADDR_W-1:0] dr_req_addr,
    output logic              dr_req_ready,
    output logic [DATA_W-1:0] dr_rdata,
    output logic              dr_rdata_valid,
    output logic              dr_rdata_last,
    input  logic              dw_req_valid,
    input  logic [ADDR_W-1:0] dw_req_addr,
    output logic              dw_req_ready,
    input  logic [DATA_W-1:0] dw_wdata,
    input  logic              dw_wdata_valid,
    output logic              dw_wdata_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              busy,
    output logic [1:0]        owner
);
    localparam int BW = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    arb_state_t        state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    owner_t            last_grant_q, last_grant_d, owner_q, owner_d, grant_id;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        grant;
    logic              in_idle, in_req, in_wd, in_rd, ic_own, dr_own, wr_fire, rd_fire;

    rr_arbiter3 u_rr (
        .req        ({dw_req_valid, dr_req_valid, ic_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign in_idle = state_q == IDLE;
    assign in_req  = state_q == REQ;
    assign in_wd   = state_q == WDATA;
    assign in_rd   = state_q == RDATA;
    assign ic_own  = in_rd && owner_q == OWN_IC;
    assign dr_own  = in_rd && owner_q == OWN_DR;
    assign wr_fire = in_wd && dw_wdata_valid && mem_wdata_ready;
    assign rd_fire = in_rd && mem_rdata_valid;

    // accept pulses are masked while reset is held so every output reads idle during reset
    assign {dw_req_ready, dr_req_ready, ic_req_ready} = (rst_n && in_idle) ? grant : 3'b000;
    assign ic_rdata        = ic_own ? mem_rdata : '0;
    assign ic_rdata_valid  = ic_own && mem_rdata_valid;
    assign ic_rdata_last   = ic_own && beat_cnt_q == LAST_BEAT;
    assign dr_rdata        = dr_own ? mem_rdata : '0;
    assign dr_rdata_valid  = dr_own && mem_rdata_valid;
    assign dr_rdata_last   = dr_own && beat_cnt_q == LAST_BEAT;
    assign mem_req_valid   = in_req;
    assign mem_req_addr    = addr_q;
    assign mem_req_we      = we_q;
    assign mem_wdata       = in_wd ? dw_wdata : '0;
    assign mem_wdata_valid = in_wd && dw_wdata_valid;
    assign dw_wdata_ready  = in_wd && mem_wdata_ready;
    assign busy            = !in_idle;
    assign owner           = owner_q;

    // next-state: accept in IDLE, handshake in REQ, count beats until the line completes
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        if (in_idle && grant_id != OWN_NONE) begin
            state_d      = REQ;
            owner_d      = grant_id;
            last_grant_d = grant_id;
            we_d         = grant_id == OWN_DW;
            addr_d       = grant_id == OWN_IC ? ic_req_addr : grant_id == OWN_DR ? dr_req_addr : dw_req_addr;
        end
        if (in_req && mem_req_ready) begin
            state_d    = we_q ? WDATA : RDATA;
            beat_cnt_d = '0;
        end
        if (wr_fire || rd_fire) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            state_d    = beat_cnt_q == LAST_BEAT ? IDLE : state_q;
            owner_d    = beat_cnt_q == LAST_BEAT ? OWN_NONE : owner_q;
        end
    end

    // state registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            last_grant_q <= OWN_DW;
            owner_q      <= OWN_NONE;
            addr_q       <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
        end
    end
endmodule
